// File: rtl/rsa_systolic_array.sv
// Systolic matrix-multiply engine: buffers A (X-by-N) and B (N-by-Y), runs an X-by-Y MAC grid,
// then streams C row-major as one contiguous valid-qualified burst.
module rsa_systolic_array #(
    parameter int unsigned X          = 3,
    parameter int unsigned N          = 3,
    parameter int unsigned Y          = 3,
    parameter int unsigned IN_LEN     = 4,
    parameter int unsigned OUT_LEN    = 8,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic               clk,
    input  logic               sys_rst_n,
    input  logic               Xin_val,
    input  logic [IN_LEN:1]    Xin_data,
    input  logic               Yin_val,
    input  logic [IN_LEN:1]    Yin_data,
    output logic               out_val,
    output logic [OUT_LEN:1]   out_data
);

    localparam int unsigned XN     = X * N;
    localparam int unsigned YN     = Y * N;
    localparam int unsigned XY     = X * Y;
    localparam int unsigned XCW    = $clog2(XN + 1);
    localparam int unsigned YCW    = $clog2(YN + 1);
    localparam int unsigned RW     = (X > 1) ? $clog2(X) : 1;
    localparam int unsigned CW     = (Y > 1) ? $clog2(Y) : 1;
    localparam int unsigned KW     = ADDR_WIDTH;
    localparam int unsigned TW     = $clog2(N + X + Y);
    localparam int unsigned DW     = (XY > 1) ? $clog2(XY) : 1;
    localparam int unsigned LAST_T = N + X + Y - 2;

    localparam logic [XCW-1:0] XN_C      = XCW'(XN);
    localparam logic [YCW-1:0] YN_C      = YCW'(YN);
    localparam logic [TW-1:0]  LAST_T_C  = TW'(LAST_T);
    localparam logic [DW-1:0]  XY_LAST_C = DW'(XY - 1);

    typedef enum logic [1:0] {StLoad, StCompute, StDrain} state_e;

    state_e state_q, state_d;

    logic [XCW-1:0]    x_cnt_q;
    logic [YCW-1:0]    y_cnt_q;
    logic [RW-1:0]     x_row_q;
    logic [KW-1:0]     x_col_q;
    logic [KW-1:0]     y_row_q;
    logic [CW-1:0]     y_col_q;
    logic [IN_LEN:1]   a_buf [X][N];
    logic [IN_LEN:1]   b_buf [N][Y];

    logic [TW-1:0]     t_q;
    logic [IN_LEN:1]   a_edge [X];
    logic [IN_LEN:1]   b_edge [Y];
    logic [IN_LEN:1]   a_in   [X][Y];
    logic [IN_LEN:1]   b_in   [X][Y];
    logic [IN_LEN:1]   a_pipe [X][Y];
    logic [IN_LEN:1]   b_pipe [X][Y];
    logic [OUT_LEN:1]  acc    [X][Y];

    logic [DW-1:0]     d_cnt_q;
    logic [RW-1:0]     dr_row_q;
    logic [CW-1:0]     dr_col_q;

    function automatic logic [OUT_LEN:1] mac(input logic [OUT_LEN:1] acc_in,
                                             input logic [IN_LEN:1]  a,
                                             input logic [IN_LEN:1]  b);
        logic [2*IN_LEN-1:0] prod;
        prod = {{IN_LEN{1'b0}}, a} * {{IN_LEN{1'b0}}, b};
        return acc_in + OUT_LEN'(prod);
    endfunction

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLoad:    if (x_cnt_q == XN_C && y_cnt_q == YN_C) state_d = StCompute;
            StCompute: if (t_q == LAST_T_C) state_d = StDrain;
            StDrain:   if (d_cnt_q == XY_LAST_C) state_d = StLoad;
            default:   state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            state_q <= StLoad;
        end else begin
            state_q <= state_d;
        end
    end

    // Input buffers: A stored as rows of N, B as rows of Y; extra beats past full are dropped.
    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            x_cnt_q <= '0;
            y_cnt_q <= '0;
            x_row_q <= '0;
            x_col_q <= '0;
            y_row_q <= '0;
            y_col_q <= '0;
            for (int i = 0; i < X; i++) begin
                for (int k = 0; k < N; k++) begin
                    a_buf[i][k] <= '0;
                end
            end
            for (int k = 0; k < N; k++) begin
                for (int j = 0; j < Y; j++) begin
                    b_buf[k][j] <= '0;
                end
            end
        end else if (state_q != StLoad) begin
            x_cnt_q <= '0;
            y_cnt_q <= '0;
            x_row_q <= '0;
            x_col_q <= '0;
            y_row_q <= '0;
            y_col_q <= '0;
        end else begin
            if (Xin_val && x_cnt_q < XN_C) begin
                a_buf[x_row_q][x_col_q] <= Xin_data;
                x_cnt_q <= x_cnt_q + XCW'(1);
                if (x_col_q == KW'(N - 1)) begin
                    x_col_q <= '0;
                    x_row_q <= x_row_q + RW'(1);
                end else begin
                    x_col_q <= x_col_q + KW'(1);
                end
            end
            if (Yin_val && y_cnt_q < YN_C) begin
                b_buf[y_row_q][y_col_q] <= Yin_data;
                y_cnt_q <= y_cnt_q + YCW'(1);
                if (y_col_q == CW'(Y - 1)) begin
                    y_col_q <= '0;
                    y_row_q <= y_row_q + KW'(1);
                end else begin
                    y_col_q <= y_col_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!sys_rst_n || state_q != StCompute) begin
            t_q <= '0;
        end else begin
            t_q <= t_q + TW'(1);
        end
    end

    // Skewed edge feeds: row i sees A[i][t-i], column j sees B[t-j][j], zero outside the window.
    always_comb begin
        for (int i = 0; i < X; i++) begin
            a_edge[i] = '0;
            for (int k = 0; k < N; k++) begin
                if (state_q == StCompute && t_q == TW'(i + k)) a_edge[i] = a_buf[i][k];
            end
        end
        for (int j = 0; j < Y; j++) begin
            b_edge[j] = '0;
            for (int k = 0; k < N; k++) begin
                if (state_q == StCompute && t_q == TW'(j + k)) b_edge[j] = b_buf[k][j];
            end
        end
    end

    for (genvar gi = 0; gi < X; gi++) begin : g_row
        for (genvar gj = 0; gj < Y; gj++) begin : g_col
            if (gj == 0) begin : g_a_edge
                assign a_in[gi][gj] = a_edge[gi];
            end else begin : g_a_pass
                assign a_in[gi][gj] = a_pipe[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign b_in[gi][gj] = b_edge[gj];
            end else begin : g_b_pass
                assign b_in[gi][gj] = b_pipe[gi-1][gj];
            end
        end
    end

    // Pipes are flushed outside COMPUTE; accumulators survive into DRAIN and clear back in LOAD.
    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < X; i++) begin
                for (int j = 0; j < Y; j++) begin
                    a_pipe[i][j] <= '0;
                    b_pipe[i][j] <= '0;
                    acc[i][j]    <= '0;
                end
            end
        end else begin
            for (int i = 0; i < X; i++) begin
                for (int j = 0; j < Y; j++) begin
                    if (state_q == StCompute) begin
                        a_pipe[i][j] <= a_in[i][j];
                        b_pipe[i][j] <= b_in[i][j];
                        acc[i][j]    <= mac(acc[i][j], a_in[i][j], b_in[i][j]);
                    end else begin
                        a_pipe[i][j] <= '0;
                        b_pipe[i][j] <= '0;
                        if (state_q == StLoad) acc[i][j] <= '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            out_val  <= 1'b0;
            out_data <= '0;
            d_cnt_q  <= '0;
            dr_row_q <= '0;
            dr_col_q <= '0;
        end else if (state_q == StDrain) begin
            out_val  <= 1'b1;
            out_data <= acc[dr_row_q][dr_col_q];
            d_cnt_q  <= d_cnt_q + DW'(1);
            if (dr_col_q == CW'(Y - 1)) begin
                dr_col_q <= '0;
                dr_row_q <= dr_row_q + RW'(1);
            end else begin
                dr_col_q <= dr_col_q + CW'(1);
            end
        end else begin
            out_val  <= 1'b0;
            d_cnt_q  <= '0;
            dr_row_q <= '0;
            dr_col_q <= '0;
        end
    end

endmodule

// File: tb/tb_rsa_systolic_array.sv
// Directed bench for rsa_systolic_array: a matmul model fills a scoreboard queue at load time,
// a negedge monitor pops and compares each out_val beat.
module tb_rsa_systolic_array;

    localparam int unsigned X       = 3;
    localparam int unsigned N       = 3;
    localparam int unsigned Y       = 3;
    localparam int unsigned IN_LEN  = 4;
    localparam int unsigned OUT_LEN = 8;
    localparam int          XN      = X * N;
    localparam int          YN      = Y * N;
    localparam int          XY      = X * Y;
    localparam int          LAT     = N + X + Y + 2;

    logic               clk = 1'b0;
    logic               sys_rst_n;
    logic               Xin_val;
    logic [IN_LEN:1]    Xin_data;
    logic               Yin_val;
    logic [IN_LEN:1]    Yin_data;
    logic               out_val;
    logic [OUT_LEN:1]   out_data;

    rsa_systolic_array #(
        .X(X), .N(N), .Y(Y), .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .ADDR_WIDTH(2)
    ) dut (
        .clk(clk),
        .sys_rst_n(sys_rst_n),
        .Xin_val(Xin_val),
        .Xin_data(Xin_data),
        .Yin_val(Yin_val),
        .Yin_data(Yin_data),
        .out_val(out_val),
        .out_data(out_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [OUT_LEN:1] exp_q[$];
    logic [IN_LEN:1]  ma [XN];
    logic [IN_LEN:1]  mb [YN];

    logic prev_val    = 1'b0;
    int   run_cnt     = 0;
    int   run_start   = 0;
    int   bursts_done = 0;
    int   bursts_base = 0;
    int   done_start  = -1;
    int   beat_idx    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: every beat must have a pending expectation and match it.
    initial begin
        forever begin
            @(negedge clk);
            if (out_val === 1'b1) begin
                if (!prev_val) begin
                    run_cnt   = 1;
                    run_start = cyc;
                end else begin
                    run_cnt++;
                end
                check("beat_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    check($sformatf("beat%0d_data", beat_idx), 32'(out_data), 32'(exp_q.pop_front()));
                end
                beat_idx++;
                if (run_cnt == XY) begin
                    bursts_done++;
                    done_start = run_start;
                end
            end
            prev_val = (out_val === 1'b1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_expected();
        for (int i = 0; i < X; i++) begin
            for (int j = 0; j < Y; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < N; k++) begin
                    s += int'(ma[i*N+k]) * int'(mb[k*Y+j]);
                end
                exp_q.push_back(OUT_LEN'(s));
            end
        end
    endtask

    // Drives both streams from the current time; done_cyc is the cycle the last needed beat was set.
    task automatic drive_job(input int x_start, input int y_start, input int x_beats,
                             output int done_cyc);
        int total;
        int xd;
        int yd;
        xd = -1;
        yd = -1;
        total = (x_start + x_beats > y_start + YN) ? x_start + x_beats : y_start + YN;
        bursts_base = bursts_done;
        push_expected();
        for (int c = 0; c < total; c++) begin
            int xi;
            int yi;
            xi = c - x_start;
            yi = c - y_start;
            if (xi >= 0 && xi < x_beats) begin
                Xin_val  = 1'b1;
                Xin_data = (xi < XN) ? ma[xi] : 4'hF;
                if (xi == XN - 1) xd = cyc;
            end else begin
                Xin_val  = 1'b0;
                Xin_data = '0;
            end
            if (yi >= 0 && yi < YN) begin
                Yin_val  = 1'b1;
                Yin_data = mb[yi];
                if (yi == YN - 1) yd = cyc;
            end else begin
                Yin_val  = 1'b0;
                Yin_data = '0;
            end
            step();
        end
        Xin_val  = 1'b0;
        Yin_val  = 1'b0;
        done_cyc = (xd > yd) ? xd : yd;
    endtask

    task automatic wait_burst(input string tag, input int exp_start);
        int n;
        n = 0;
        while (bursts_done == bursts_base && n < 200) begin
            step();
            n++;
        end
        check({tag, "_burst_seen"}, 32'(bursts_done - bursts_base), 1);
        check({tag, "_first_beat_cyc"}, 32'(done_start), 32'(exp_start));
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 0);
    endtask

    task automatic check_burst_end(input string tag);
        step();
        check({tag, "_val_drops"}, 32'(out_val), 0);
    endtask

    initial begin
        int dc;
        int n;
        sys_rst_n = 1'b0;
        Xin_val   = 1'b0;
        Xin_data  = '0;
        Yin_val   = 1'b0;
        Yin_data  = '0;
        repeat (3) step();
        check("reset_out_val", 32'(out_val), 0);
        check("reset_out_data", 32'(out_data), 0);
        sys_rst_n = 1'b1;
        step();

        // Identity B, both streams together.
        ma = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        mb = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        drive_job(0, 0, XN, dc);
        wait_burst("ident", dc + LAT);
        check_burst_end("ident");

        // Mixed B.
        mb = '{1, 0, 2, 0, 1, 0, 3, 0, 1};
        drive_job(0, 0, XN, dc);
        wait_burst("mixed", dc + LAT);
        check_burst_end("mixed");

        // All 0xF: each sum 675 wraps to 0xA3.
        for (int i = 0; i < XN; i++) ma[i] = 4'hF;
        for (int i = 0; i < YN; i++) mb[i] = 4'hF;
        drive_job(0, 0, XN, dc);
        wait_burst("allf", dc + LAT);
        check_burst_end("allf");

        // B first, A five cycles later with 12 trailing garbage beats.
        ma = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        mb = '{1, 0, 2, 0, 1, 0, 3, 0, 1};
        drive_job(5, 0, 21, dc);
        wait_burst("garbage", dc + LAT);
        check_burst_end("garbage");

        // Reset after four drain beats: remaining beats must never appear.
        ma = '{2, 4, 6, 8, 1, 3, 5, 7, 9};
        drive_job(0, 0, XN, dc);
        n = 0;
        while (!(prev_val && run_cnt == 4) && n < 200) begin
            step();
            n++;
        end
        check("rst_reached_4_beats", 32'(run_cnt), 4);
        sys_rst_n = 1'b0;
        exp_q.delete();
        step();
        check("rst_val_drop", 32'(out_val), 0);
        check("rst_data_clear", 32'(out_data), 0);
        repeat (2) step();
        sys_rst_n = 1'b1;
        repeat (15) step();
        check("rst_no_more_beats", 32'(run_cnt), 4);
        check("rst_idle_val", 32'(out_val), 0);

        drive_job(0, 0, XN, dc);
        wait_burst("reload", dc + LAT);
        check_burst_end("reload");

        // Back-to-back: second load starts right on the final drain beat of the first.
        for (int i = 0; i < XN; i++) ma[i] = 4'($urandom_range(0, 15));
        for (int i = 0; i < YN; i++) mb[i] = 4'($urandom_range(0, 15));
        drive_job(0, 2, XN, dc);
        wait_burst("b2b_first", dc + LAT);
        for (int i = 0; i < XN; i++) ma[i] = 4'($urandom_range(0, 15));
        for (int i = 0; i < YN; i++) mb[i] = 4'($urandom_range(0, 15));
        drive_job(0, 0, XN, dc);
        wait_burst("b2b_second", dc + LAT);
        check_burst_end("b2b_second");

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
